// File: rtl/xor_cipher_rx_if.sv
// Plaintext word stream leaving the XOR cipher receiver: data plus valid/ready handshake.
// The receiver drives it through the master modport; the consumer uses the slave modport.
interface xor_cipher_rx_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] oWord;
  logic             oWord_valid;
  logic             iWord_ready;

  modport master (
    output oWord,
    output oWord_valid,
    input  iWord_ready
  );

  modport slave (
    input  oWord,
    input  oWord_valid,
    output iWord_ready
  );
endinterface

// File: rtl/xor_cipher_rx.sv
// XOR cipher receiver: MSB-first deserializer, key XOR, small output FIFO with valid/ready.
// Optional frame-length checker (oLen_err) enabled by defining XOR_RX_LEN_CHECK_EN.
module xor_cipher_rx #(
  parameter int KEY_SIZE   = 32,
  parameter int MSG_SIZE   = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic                iKey_load,
  input  logic                iSerial_in,
  input  logic                iSerial_start,
  input  logic                iSerial_end,
  xor_cipher_rx_if.master     word_if,
  output logic                oFrame_done,
  output logic                oOverflow,
  output logic                oBusy
`ifdef XOR_RX_LEN_CHECK_EN
  ,output logic               oLen_err
`endif
);

  localparam int CNT_W = $clog2(KEY_SIZE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if ((MSG_SIZE % KEY_SIZE) != 0) begin : g_bad_msg_size
    $error("MSG_SIZE must be a multiple of KEY_SIZE");
  end

  typedef enum logic {IDLE, RECV} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [KEY_SIZE-1:0] r_key;
  logic [KEY_SIZE-1:0] r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_frame_done;
  logic                r_overflow;

  logic [KEY_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;

  logic                w_sample;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [KEY_SIZE-1:0] w_shift_nxt;
  logic                w_word_done;
  logic [KEY_SIZE-1:0] w_word;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push_ok;

  // ---------------- state machine ----------------
  // NOTE: every register in this design is written with <= so all flops see pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (iSerial_start && !iSerial_end) w_state_nxt = RECV;
      RECV:    if (iSerial_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oBusy               = (r_state == RECV);
    word_if.oWord_valid = !w_empty;
    word_if.oWord       = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  end

  // ---------------- deserializer ----------------
  // A start strobe (fresh or restart) always begins a new word with this bit as bit 1.
  assign w_sample    = iSerial_start || (r_state == RECV);
  assign w_cnt_nxt   = (iSerial_start ? '0 : r_bit_cnt) + CNT_W'(1);
  assign w_shift_nxt = {(iSerial_start ? {(KEY_SIZE-1){1'b0}} : r_shift[KEY_SIZE-2:0]), iSerial_in};
  assign w_word_done = w_sample && (w_cnt_nxt == CNT_W'(KEY_SIZE));
  assign w_word      = w_shift_nxt ^ r_key;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_key        <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (r_state == IDLE && iKey_load) r_key <= iKey;
      if (w_sample) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= (w_word_done || iSerial_end) ? '0 : w_cnt_nxt;
      end
      r_frame_done <= w_sample && iSerial_end;
    end
  end

  assign oFrame_done = r_frame_done;

  // ---------------- output FIFO ----------------
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop     = !w_empty && word_if.iWord_ready;
  assign w_push_ok = w_word_done && (!w_full || w_pop);

  // NOTE: storage is not reset; oWord is forced to 0 while empty, so stale entries are never visible.
  always_ff @(posedge iClk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_word_done && w_full && !w_pop)        r_overflow <= 1'b1;
      else if (r_state == IDLE && iSerial_start)  r_overflow <= 1'b0;
    end
  end

  assign oOverflow = r_overflow;

`ifdef XOR_RX_LEN_CHECK_EN
  // ---------------- frame length checker ----------------
  localparam int LEN_W = $clog2(MSG_SIZE + 1) + 1;

  logic [LEN_W-1:0] r_len_cnt;
  logic             r_aborted;
  logic             r_len_err;
  logic [LEN_W-1:0] w_len_base;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_aborted_nxt;

  // The count spans the whole frame including bits before a restart; it saturates.
  assign w_len_base    = (r_state == IDLE) ? '0 : r_len_cnt;
  assign w_len_nxt     = (&w_len_base) ? w_len_base : w_len_base + 1'b1;
  assign w_aborted_nxt = (r_state == RECV) && (iSerial_start || r_aborted);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_len_cnt <= '0;
      r_aborted <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      if (w_sample) begin
        r_len_cnt <= w_len_nxt;
        r_aborted <= w_aborted_nxt;
      end
      r_len_err <= w_sample && iSerial_end &&
                   ((w_len_nxt != LEN_W'(MSG_SIZE)) || w_aborted_nxt);
    end
  end

  assign oLen_err = r_len_err;
`endif

endmodule

// File: tb/tb_xor_cipher_rx.sv
// Randomised and directed bench for xor_cipher_rx, checked every cycle against a queue-based model.
module tb_xor_cipher_rx;
  localparam int KS = 32;
  localparam int MS = 512;
  localparam int FD = 4;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic [KS-1:0] iKey = '0;
  logic          iKey_load = 1'b0;
  logic          iSerial_in = 1'b0;
  logic          iSerial_start = 1'b0;
  logic          iSerial_end = 1'b0;
  logic          oFrame_done;
  logic          oOverflow;
  logic          oBusy;
`ifdef XOR_RX_LEN_CHECK_EN
  logic          oLen_err;
`endif

  xor_cipher_rx_if #(.WIDTH(KS)) word_if ();

  xor_cipher_rx #(.KEY_SIZE(KS), .MSG_SIZE(MS), .FIFO_DEPTH(FD)) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iKey          (iKey),
    .iKey_load     (iKey_load),
    .iSerial_in    (iSerial_in),
    .iSerial_start (iSerial_start),
    .iSerial_end   (iSerial_end),
    .word_if       (word_if),
    .oFrame_done   (oFrame_done),
    .oOverflow     (oOverflow),
    .oBusy         (oBusy)
`ifdef XOR_RX_LEN_CHECK_EN
    ,.oLen_err     (oLen_err)
`endif
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [KS-1:0] m_key;
  bit          m_in_frame;
  int          m_nbits;
  bit [KS-1:0] m_acc;
  bit [KS-1:0] m_q[$];
  bit          m_ovf;
  bit          m_fd;
  bit          m_lerr;
  int          m_total;
  bit          m_aborted;

  always @(posedge iClk) begin
    bit pop, push, was_idle;
    bit [KS-1:0] pw;
    int sz;
    if (iRst) begin
      m_key = '0; m_in_frame = 0; m_nbits = 0; m_acc = '0; m_q.delete();
      m_ovf = 0; m_fd = 0; m_lerr = 0; m_total = 0; m_aborted = 0;
    end else begin
      m_fd = 0; m_lerr = 0; push = 0; pw = '0;
      sz = m_q.size();
      pop = word_if.iWord_ready && (sz > 0);
      was_idle = !m_in_frame;
      if (iSerial_start || m_in_frame) begin
        if (iSerial_start) begin
          if (was_idle) begin m_ovf = 0; m_aborted = 0; m_total = 0; end
          else m_aborted = 1;
          m_nbits = 0; m_acc = '0;
        end
        m_acc = (m_acc << 1) | KS'(iSerial_in);
        m_nbits++;
        if (m_total < 2047) m_total++;
        if (m_nbits == KS) begin push = 1; pw = m_acc ^ m_key; m_nbits = 0; end
        m_in_frame = 1;
        if (iSerial_end) begin
          m_in_frame = 0; m_nbits = 0; m_fd = 1;
          m_lerr = (m_total != MS) || m_aborted;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz < FD || pop) m_q.push_back(pw);
        else m_ovf = 1;
      end
      if (was_idle && iKey_load) m_key = iKey;
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  bit          cmp_en = 0;
  bit [KS-1:0] popped[$];
  int          fd_count = 0;
  int          lerr_count = 0;

  always @(negedge iClk) begin
    if (cmp_en) begin
      check("word_valid", 32'(word_if.oWord_valid), 32'(m_q.size() > 0));
      check("word", word_if.oWord, (m_q.size() > 0) ? m_q[0] : '0);
      check("frame_done", 32'(oFrame_done), 32'(m_fd));
      check("overflow", 32'(oOverflow), 32'(m_ovf));
      check("busy", 32'(oBusy), 32'(m_in_frame));
`ifdef XOR_RX_LEN_CHECK_EN
      check("len_err", 32'(oLen_err), 32'(m_lerr));
      if (oLen_err) lerr_count++;
`endif
      if (word_if.oWord_valid && word_if.iWord_ready) popped.push_back(word_if.oWord);
      if (oFrame_done) fd_count++;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit tx_bits[$];
  int ready_mode = 0;  // 0 low, 1 high, 2 random

  function automatic void add_word(input bit [KS-1:0] w);
    for (int b = KS - 1; b >= 0; b--) tx_bits.push_back(w[b]);
  endfunction

  function automatic logic ready_val(input bit force_hi);
    if (force_hi) return 1'b1;
    case (ready_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      word_if.iWord_ready = ready_val(0);
      @(posedge iClk); #1;
    end
  endtask

  task automatic load_key(input logic [KS-1:0] k);
    iKey = k; iKey_load = 1'b1;
    word_if.iWord_ready = ready_val(0);
    @(posedge iClk); #1;
    iKey_load = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input int restart_at, input int ready_pulse_at,
                           input int keyload_at, input int rst_at);
    for (int i = 0; i < nbits; i++) begin
      iSerial_in          = tx_bits[i];
      iSerial_start       = (i == 0) || (i == restart_at);
      iSerial_end         = (i == nbits - 1);
      word_if.iWord_ready = ready_val(i == ready_pulse_at);
      iKey_load           = (i == keyload_at);
      if (i == keyload_at) iKey = 32'hFFFF_FFFF;
      iRst                = (i == rst_at);
      @(posedge iClk); #1;
      if (i == rst_at) break;
    end
    iSerial_in = 1'b0; iSerial_start = 1'b0; iSerial_end = 1'b0;
    iKey_load = 1'b0; iRst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    word_if.iWord_ready = 1'b0;
    @(posedge iClk); #1;
    cmp_en = 1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    check("rst_valid", 32'(word_if.oWord_valid), 32'h0);
    check("rst_word", word_if.oWord, 32'h0);
    check("rst_overflow", 32'(oOverflow), 32'h0);
    check("rst_busy", 32'(oBusy), 32'h0);
    check("rst_frame_done", 32'(oFrame_done), 32'h0);

    // Key load and a full 512-bit frame with ready held high
    load_key(32'hA5A5_5A5A);
    tx_bits.delete();
    for (int n = 0; n < 16; n++) add_word(32'hA5A5_5A5A ^ 32'(n));
    ready_mode = 1; popped.delete(); fd_count = 0;
    run_frame(512, -1, -1, -1, -1);
    idle(4);
    check("t1_count", 32'(popped.size()), 32'd16);
    for (int n = 0; n < 16 && n < popped.size(); n++) check("t1_word", popped[n], 32'(n));
    check("t1_frame_done", 32'(fd_count), 32'd1);
    check("t1_overflow", 32'(oOverflow), 32'h0);

    // Backpressure for the whole frame: words 4..15 dropped
    ready_mode = 0; popped.delete();
    run_frame(512, -1, -1, -1, -1);
    idle(2);
    check("t2_overflow", 32'(oOverflow), 32'h1);
    check("t2_valid", 32'(word_if.oWord_valid), 32'h1);
    ready_mode = 1;
    idle(8);
    check("t2_count", 32'(popped.size()), 32'd4);
    for (int n = 0; n < 4 && n < popped.size(); n++) check("t2_word", popped[n], 32'(n));

    // Full FIFO with push and pop in the same cycle
    tx_bits.delete();
    for (int n = 0; n < 5; n++) add_word(32'hA5A5_5A5A ^ 32'(n));
    ready_mode = 0;
    run_frame(160, -1, 159, -1, -1);
    idle(2);
    check("t3_overflow", 32'(oOverflow), 32'h0);
    popped.delete();
    ready_mode = 1;
    idle(8);
    check("t3_count", 32'(popped.size()), 32'd4);
    for (int n = 0; n < 4 && n < popped.size(); n++) check("t3_word", popped[n], 32'(n + 1));

    // Restart at bit 40
    tx_bits.delete();
    add_word(32'hA5A5_5A5A ^ 32'h11);
    for (int b = 0; b < 7; b++) tx_bits.push_back(1'($urandom));
    add_word(32'hA5A5_5A5A ^ 32'h22);
    add_word(32'hA5A5_5A5A ^ 32'h33);
    popped.delete(); fd_count = 0; lerr_count = 0;
    run_frame(103, 39, -1, -1, -1);
    idle(3);
    check("t4_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      check("t4_word0", popped[0], 32'h11);
      check("t4_word1", popped[1], 32'h22);
      check("t4_word2", popped[2], 32'h33);
    end
    check("t4_frame_done", 32'(fd_count), 32'd1);
`ifdef XOR_RX_LEN_CHECK_EN
    check("t4_len_err", 32'(lerr_count), 32'd1);
`endif

    // 48-bit frame with a key load attempted during RECV
    tx_bits.delete();
    add_word(32'hA5A5_5A5A ^ 32'h1234_5678);
    for (int b = 0; b < 16; b++) tx_bits.push_back(1'($urandom));
    popped.delete(); fd_count = 0; lerr_count = 0;
    run_frame(48, -1, -1, 10, -1);
    idle(3);
    check("t5_count", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) check("t5_word", popped[0], 32'h1234_5678);
    check("t5_frame_done", 32'(fd_count), 32'd1);
`ifdef XOR_RX_LEN_CHECK_EN
    check("t5_len_err", 32'(lerr_count), 32'd1);
`endif
    tx_bits.delete();
    add_word(32'hA5A5_5A5A ^ 32'hCAFE_F00D);
    popped.delete();
    run_frame(32, -1, -1, -1, -1);
    idle(3);
    if (popped.size() == 1) check("t5_key_kept", popped[0], 32'hCAFE_F00D);
    else check("t5_key_count", 32'(popped.size()), 32'd1);

    // Reset at bit 20, then reload key and decode
    tx_bits.delete();
    for (int n = 0; n < 16; n++) add_word(32'($urandom));
    run_frame(512, -1, -1, -1, 19);
    check("t6_valid", 32'(word_if.oWord_valid), 32'h0);
    check("t6_busy", 32'(oBusy), 32'h0);
    check("t6_overflow", 32'(oOverflow), 32'h0);
    check("t6_frame_done", 32'(oFrame_done), 32'h0);
    check("t6_word", word_if.oWord, 32'h0);
    load_key(32'h0F0F_3C3C);
    tx_bits.delete();
    add_word(32'h0F0F_3C3C ^ 32'hDEAD_BEEF);
    add_word(32'h0F0F_3C3C ^ 32'h0000_0001);
    popped.delete();
    run_frame(64, -1, -1, -1, -1);
    idle(3);
    check("t6_count", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      check("t6_word0", popped[0], 32'hDEAD_BEEF);
      check("t6_word1", popped[1], 32'h0000_0001);
    end

    // Randomised frames, lengths, restarts, key loads and backpressure
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int len, rs;
      if ($urandom_range(0, 3) == 0) load_key(32'($urandom));
      len = ($urandom_range(0, 4) == 0) ? MS : int'($urandom_range(1, 200));
      rs  = ($urandom_range(0, 3) == 0 && len > 2) ? int'($urandom_range(1, len - 1)) : -1;
      tx_bits.delete();
      for (int b = 0; b < len; b++) tx_bits.push_back(1'($urandom));
      run_frame(len, rs, -1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1, -1);
      idle(int'($urandom_range(0, 6)));
    end
    ready_mode = 1;
    idle(8);
    check("final_empty", 32'(word_if.oWord_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/xor_cipher_rx.md
Name: xor_cipher_rx

Overview:
- Receive end of the XOR cipher serial output (serial data plus start/end frame strobes).
- Deserializes the ciphertext MSB-first into KEY_SIZE-bit words and XORs each word with a locally held key to recover plaintext.
- Pushes each plaintext word into a small output FIFO with a valid/ready handshake.
- Used on the host/bench side and for on-chip loopback of the cipher core.

Parameters:
- KEY_SIZE, 32, word and key width in bits.
- MSG_SIZE, 512, nominal frame length in bits; must be a multiple of KEY_SIZE.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  reset, synchronous, active-high.
- iKey  in  KEY_SIZE  decryption key.
- iKey_load  in  1  latches iKey into the key register; honoured only in IDLE.
- iSerial_in  in  1  ciphertext bit, sampled every clock while a frame is active.
- iSerial_start  in  1  high in the same cycle as the first (MSB) bit of a frame.
- iSerial_end  in  1  high in the same cycle as the last bit of a frame.
- oWord  out  KEY_SIZE  plaintext word at the FIFO head.
- oWord_valid  out  1  FIFO not empty.
- iWord_ready  in  1  consumer accepts oWord; a pop occurs when valid and ready are both high.
- oFrame_done  out  1  one-cycle pulse after the end bit is sampled.
- oOverflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- oBusy  out  1  high in RECV.

Behaviour:
- Reset: state IDLE; key register 0; shift register 0; bit counter 0; FIFO empty; oWord 0; oWord_valid 0; oFrame_done 0; oOverflow 0; oBusy 0.
- State machine (IDLE, RECV):
  - IDLE → RECV when iSerial_start=1. The bit present in that cycle is sampled as bit 1.
  - RECV → IDLE on the cycle iSerial_end=1, after that bit is sampled.
  - Start and end together in IDLE: a one-bit frame. Return to IDLE and pulse oFrame_done.
- Bits are sampled only in the start cycle and in RECV; iSerial_in is ignored in IDLE.
- Shift register shifts left, new bit in the LSB. The bit counter counts 1..KEY_SIZE and wraps to 0 when a word completes.
- Word completion:
  - On the edge sampling the KEY_SIZE-th bit, push {shift[KEY_SIZE-2:0], iSerial_in} XOR key into the FIFO.
  - oWord_valid rises one cycle later (latency 1 from the last bit).
- A partial word left when end arrives is discarded and the counter is cleared.
- iSerial_start while in RECV aborts the current frame: partial word discarded, counter restarted with this bit as bit 1, state stays RECV. Words already pushed remain in the FIFO.
- iKey_load in RECV is ignored. The key register is stable for the whole frame.
- FIFO:
  - Push and pop in the same cycle are legal in every fill state, including full (no overflow in that case).
  - Push when full with no pop: word dropped and oOverflow set. oOverflow clears only on reset or on iSerial_start from IDLE.
  - Pop when empty: no effect.
  - oWord is the head entry and holds steady while valid and not ready.
- oFrame_done is registered: high exactly one cycle, the cycle after the end-bit sample. It is independent of FIFO state.
- oBusy = (state == RECV).
- iRst mid-frame: all state returns to reset values at the next edge. FIFO contents and the key are lost.

Optional Feature:
- Macro XOR_RX_LEN_CHECK_EN.
- Defined:
  - Adds output oLen_err (1 bit, reset 0), which counts total frame bits with a counter sized to MSG_SIZE plus one bit.
  - oLen_err pulses together with oFrame_done when the frame bit count ≠ MSG_SIZE, or when a frame was aborted by a restart.
  - The counter saturates at its maximum rather than wrapping.
- Undefined: no port, no counter; the frame length is unchecked.

Test Plan:
- Key load and single frame:
  - Stimulus: load key 0xA5A5_5A5A; send a 512-bit frame of ciphertext words 0xA5A5_5A5A ^ n, n=0..15; iWord_ready held 1.
  - Response: 16 words 0x0000_0000..0x0000_000F in order, each valid one cycle after its 32nd bit; oFrame_done pulses once; oOverflow stays 0.
- Backpressure and overflow:
  - Stimulus: iWord_ready=0 for the whole frame.
  - Response: FIFO holds words 0..3; words 4..15 dropped; oOverflow=1 after word 4; afterwards popping yields 0,1,2,3 only.
- Full FIFO with simultaneous push and pop:
  - Stimulus: fill the FIFO to 4 entries, then assert ready in the exact cycle word 5 completes.
  - Response: no overflow; the next word read is entry 2.
- Restart mid-frame:
  - Stimulus: iSerial_start at bit 40 of a frame.
  - Response: first word kept; bits 33..39 discarded; oBusy stays 1; with XOR_RX_LEN_CHECK_EN, oLen_err pulses at the frame end.
- Partial frame and ignored key load:
  - Stimulus: a 48-bit frame, with iKey_load=1 and iKey=0xFFFF_FFFF asserted during RECV.
  - Response: one word, decrypted with the old key; oFrame_done pulses; last 16 bits discarded; oLen_err=1 if the macro is defined.
- Reset mid-frame:
  - Stimulus: iRst at bit 20.
  - Response: all outputs 0 the next cycle; the following frame decodes correctly after a key reload.
